// File: rtl/mat_port_arbiter_if.sv
// Producer/allocator/storage signal bundle for mat_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mat_port_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ID_W   = 7,
    parameter int unsigned DIM_W  = 4,
    parameter int unsigned DATA_W = 32
);
    logic [N_REQ-1:0]        sess_req;
    logic [N_REQ-1:0]        sess_gnt;
    logic [N_REQ-1:0]        own_alloc_req;
    logic [N_REQ*DIM_W-1:0]  own_m;
    logic [N_REQ*DIM_W-1:0]  own_n;
    logic [N_REQ-1:0]        own_alloc_done;
    logic [N_REQ-1:0]        own_alloc_err;
    logic [ID_W-1:0]         alloc_id_out;
    logic [N_REQ-1:0]        own_we;
    logic [N_REQ*ID_W-1:0]   own_id;
    logic [N_REQ*DIM_W-1:0]  own_row;
    logic [N_REQ*DIM_W-1:0]  own_col;
    logic [N_REQ*DATA_W-1:0] own_data;
    logic                    alloc_req;
    logic [DIM_W-1:0]        alloc_m;
    logic [DIM_W-1:0]        alloc_n;
    logic                    alloc_valid;
    logic [ID_W-1:0]         alloc_id_in;
    logic                    mem_we;
    logic [ID_W-1:0]         mem_id;
    logic [DIM_W-1:0]        mem_row;
    logic [DIM_W-1:0]        mem_col;
    logic [DATA_W-1:0]       mem_data;
    logic                    bus_err;

    modport slave (
        input  sess_req, own_alloc_req, own_m, own_n, own_we, own_id, own_row, own_col,
               own_data, alloc_valid, alloc_id_in,
        output sess_gnt, own_alloc_done, own_alloc_err, alloc_id_out, alloc_req, alloc_m,
               alloc_n, mem_we, mem_id, mem_row, mem_col, mem_data, bus_err
    );

    modport master (
        output sess_req, own_alloc_req, own_m, own_n, own_we, own_id, own_row, own_col,
               own_data, alloc_valid, alloc_id_in,
        input  sess_gnt, own_alloc_done, own_alloc_err, alloc_id_out, alloc_req, alloc_m,
               alloc_n, mem_we, mem_id, mem_row, mem_col, mem_data, bus_err
    );
endinterface

// File: rtl/mat_port_arbiter.sv
// Round-robin session arbiter sharing the matrix allocator and the storage write
// port between producers; sequences and times out each allocation handshake.
module mat_port_arbiter #(
    parameter int unsigned N_REQ         = 3,
    parameter int unsigned ID_W          = 7,
    parameter int unsigned DIM_W         = 4,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ALLOC_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mat_port_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = $clog2(ALLOC_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALLOC_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_ALLOC_WAIT} state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DIM_W-1:0]  row;
        logic [DIM_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } wr_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic [ID_W-1:0]    aid_q, aid_d;
    logic               areq_q, areq_d;
    logic [DIM_W-1:0]   am_q, am_d;
    logic [DIM_W-1:0]   an_q, an_d;
    logic               we_q, we_d;
    wr_t                wr_q, wr_d;
    logic               berr_q, berr_d;

    logic [DIM_W-1:0]   m_arr [N_REQ];
    logic [DIM_W-1:0]   n_arr [N_REQ];
    wr_t                wr_arr [N_REQ];
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               req_own;
    logic               wait_end;

    // Per-requester slices of the flattened payload buses
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_slice
        assign m_arr[i]  = bus.own_m[i*DIM_W +: DIM_W];
        assign n_arr[i]  = bus.own_n[i*DIM_W +: DIM_W];
        assign wr_arr[i] = '{id:   bus.own_id[i*ID_W +: ID_W],
                             row:  bus.own_row[i*DIM_W +: DIM_W],
                             col:  bus.own_col[i*DIM_W +: DIM_W],
                             data: bus.own_data[i*DATA_W +: DATA_W]};
    end

    assign req_own = bus.sess_req[owner_q];

    // Round-robin pick: scan downward from the farthest slot so the nearest after last_q wins
    always_comb begin : rr_pick
        logic [IDX_W-1:0] cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            cand = IDX_W'((32'(last_q) + 32'(k)) % N_REQ);
            if (bus.sess_req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        timer_d  = timer_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        aid_d    = aid_q;
        areq_d   = 1'b0;
        am_d     = am_q;
        an_d     = an_q;
        wait_end = 1'b0;

        // Write path follows the grant register; non-owner strobes are flagged and dropped
        we_d   = |(gnt_q & bus.own_we);
        wr_d   = we_d ? wr_arr[owner_q] : wr_q;
        berr_d = |((bus.own_we | bus.own_alloc_req) & ~gnt_q);

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                if (!req_own) begin
                    gnt_d   = '0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end else if (bus.own_alloc_req[owner_q]) begin
                    areq_d  = 1'b1;
                    am_d    = m_arr[owner_q];
                    an_d    = n_arr[owner_q];
                    timer_d = '0;
                    state_d = S_ALLOC_WAIT;
                end
            end
            S_ALLOC_WAIT: begin
                if (bus.alloc_valid) begin
                    aid_d    = bus.alloc_id_in;
                    done_d   = gnt_q;
                    wait_end = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    err_d    = gnt_q;
                    wait_end = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (wait_end) begin
                    if (req_own) begin
                        state_d = S_OWN;
                    end else begin
                        gnt_d   = '0;
                        last_d  = owner_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IDX_LAST;
            timer_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            aid_q   <= '0;
            areq_q  <= 1'b0;
            am_q    <= '0;
            an_q    <= '0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            aid_q   <= aid_d;
            areq_q  <= areq_d;
            am_q    <= am_d;
            an_q    <= an_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.sess_gnt       = gnt_q;
    assign bus.own_alloc_done = done_q;
    assign bus.own_alloc_err  = err_q;
    assign bus.alloc_id_out   = aid_q;
    assign bus.alloc_req      = areq_q;
    assign bus.alloc_m        = am_q;
    assign bus.alloc_n        = an_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_id         = wr_q.id;
    assign bus.mem_row        = wr_q.row;
    assign bus.mem_col        = wr_q.col;
    assign bus.mem_data       = wr_q.data;
    assign bus.bus_err        = berr_q;
endmodule

// File: tb/tb_mat_port_arbiter.sv
// Directed bench for mat_port_arbiter: per-cycle comparison against a behavioural
// session model plus hand-computed literal expectations.
module tb_mat_port_arbiter;
    localparam int unsigned N_REQ = 3, ID_W = 7, DIM_W = 4, DATA_W = 32, ALLOC_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mat_port_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DIM_W(DIM_W), .DATA_W(DATA_W)) bus ();

    mat_port_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .DIM_W(DIM_W), .DATA_W(DATA_W),
                       .ALLOC_TIMEOUT(ALLOC_TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, whether an allocation is outstanding
    int               m_owner, m_last, m_waited;
    bit               m_wait;
    logic [N_REQ-1:0] e_gnt, e_done, e_err;
    logic [ID_W-1:0]  e_aid, e_mid;
    logic             e_areq, e_we, e_berr;
    logic [DIM_W-1:0] e_am, e_an, e_row, e_col;
    logic [DATA_W-1:0] e_data;

    function automatic void model_reset();
        m_owner = -1; m_last = int'(N_REQ) - 1; m_waited = 0; m_wait = 0;
        e_gnt = '0; e_done = '0; e_err = '0; e_aid = '0; e_mid = '0; e_areq = 0;
        e_we = 0; e_berr = 0; e_am = '0; e_an = '0; e_row = '0; e_col = '0; e_data = '0;
    endfunction

    function automatic void model_step();
        int o;
        int c;
        bit rel;
        bit ended;
        o = m_owner; rel = 0; ended = 0;
        e_done = '0; e_err = '0; e_areq = 0; e_berr = 0; e_we = 0;
        for (int i = 0; i < int'(N_REQ); i++)
            if (i != o && (bus.own_we[i] || bus.own_alloc_req[i])) e_berr = 1;
        if (o >= 0 && bus.own_we[o]) begin
            e_we   = 1;
            e_mid  = bus.own_id[o*ID_W +: ID_W];
            e_row  = bus.own_row[o*DIM_W +: DIM_W];
            e_col  = bus.own_col[o*DIM_W +: DIM_W];
            e_data = bus.own_data[o*DATA_W +: DATA_W];
        end
        if (o < 0) begin
            for (int k = 1; k <= int'(N_REQ); k++) begin
                c = (m_last + k) % int'(N_REQ);
                if (m_owner < 0 && bus.sess_req[c]) m_owner = c;
            end
            if (m_owner >= 0) e_gnt = N_REQ'(1) << m_owner;
        end else if (!m_wait) begin
            if (!bus.sess_req[o]) rel = 1;
            else if (bus.own_alloc_req[o]) begin
                e_areq = 1;
                e_am = bus.own_m[o*DIM_W +: DIM_W];
                e_an = bus.own_n[o*DIM_W +: DIM_W];
                m_wait = 1; m_waited = 0;
            end
        end else begin
            if (bus.alloc_valid) begin
                e_aid = bus.alloc_id_in; e_done = N_REQ'(1) << o; ended = 1;
            end else begin
                m_waited++;
                if (m_waited == int'(ALLOC_TIMEOUT)) begin
                    e_err = N_REQ'(1) << o; ended = 1;
                end
            end
            if (ended) begin
                m_wait = 0;
                if (!bus.sess_req[o]) rel = 1;
            end
        end
        if (rel) begin
            e_gnt = '0; m_last = o; m_owner = -1;
        end
    endfunction

    // Compare process: step the model on every rising edge, check just after it
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset(); else model_step();
            #1;
            check("m_sess_gnt", 64'(bus.sess_gnt), 64'(e_gnt));
            check("m_gnt_onehot", 64'($onehot0(bus.sess_gnt)), 64'(1));
            check("m_alloc_done", 64'(bus.own_alloc_done), 64'(e_done));
            check("m_alloc_err", 64'(bus.own_alloc_err), 64'(e_err));
            check("m_alloc_id_out", 64'(bus.alloc_id_out), 64'(e_aid));
            check("m_alloc_req", 64'(bus.alloc_req), 64'(e_areq));
            check("m_alloc_m", 64'(bus.alloc_m), 64'(e_am));
            check("m_alloc_n", 64'(bus.alloc_n), 64'(e_an));
            check("m_mem_we", 64'(bus.mem_we), 64'(e_we));
            check("m_mem_id", 64'(bus.mem_id), 64'(e_mid));
            check("m_mem_row", 64'(bus.mem_row), 64'(e_row));
            check("m_mem_col", 64'(bus.mem_col), 64'(e_col));
            check("m_mem_data", 64'(bus.mem_data), 64'(e_data));
            check("m_bus_err", 64'(bus.bus_err), 64'(e_berr));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.sess_req = '0; bus.own_alloc_req = '0; bus.own_m = '0; bus.own_n = '0;
        bus.own_we = '0; bus.own_id = '0; bus.own_row = '0; bus.own_col = '0;
        bus.own_data = '0; bus.alloc_valid = 1'b0; bus.alloc_id_in = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int cycles);
        cycles = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.sess_gnt != '0) begin
                cycles = c;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_gnt: no grant within 8 cycles at %0t", $time);
    endtask

    task automatic set_wr(input int i, input int id, input int row, input int col, input int data);
        bus.own_we[i] = 1'b1;
        bus.own_id[i*ID_W +: ID_W] = ID_W'(id);
        bus.own_row[i*DIM_W +: DIM_W] = DIM_W'(row);
        bus.own_col[i*DIM_W +: DIM_W] = DIM_W'(col);
        bus.own_data[i*DATA_W +: DATA_W] = DATA_W'(data);
    endtask

    task automatic set_alloc(input int i, input int m, input int n);
        bus.own_alloc_req[i] = 1'b1;
        bus.own_m[i*DIM_W +: DIM_W] = DIM_W'(m);
        bus.own_n[i*DIM_W +: DIM_W] = DIM_W'(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int o;
        int k;
        int pulses;
        logic [N_REQ-1:0] order [4];
        logic [N_REQ-1:0] want  [4];
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
        clear_inputs();

        // Reset values, first grant, single write
        tick(); tick();
        check("rst_sess_gnt", 64'(bus.sess_gnt), 64'(0));
        check("rst_mem_we", 64'(bus.mem_we), 64'(0));
        rst = 1'b0;
        tick();
        bus.sess_req = 3'b001;
        wait_gnt(cyc);
        check("first_gnt", 64'(bus.sess_gnt), 64'(3'b001));
        check("first_gnt_latency", 64'(cyc), 64'(1));
        set_wr(0, 5, 1, 2, 7);
        tick();
        bus.own_we = '0;
        check("wr_mem_we", 64'(bus.mem_we), 64'(1));
        check("wr_mem_id", 64'(bus.mem_id), 64'(5));
        check("wr_mem_row", 64'(bus.mem_row), 64'(1));
        check("wr_mem_col", 64'(bus.mem_col), 64'(2));
        check("wr_mem_data", 64'(bus.mem_data), 64'(7));
        tick();
        check("wr_we_drop", 64'(bus.mem_we), 64'(0));
        check("wr_data_hold", 64'(bus.mem_data), 64'(7));
        bus.sess_req = '0;
        tick(); tick();

        // Round-robin rotation with an idle cycle between sessions
        do_reset();
        bus.sess_req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(cyc);
            order[g] = bus.sess_gnt;
            check("rr_gnt_latency", 64'(cyc), 64'(1));
            o = (bus.sess_gnt == 3'b001) ? 0 : (bus.sess_gnt == 3'b010) ? 1 : 2;
            repeat (4) tick();
            bus.sess_req[o] = 1'b0;
            tick();
            check("rr_idle_gap", 64'(bus.sess_gnt), 64'(0));
            bus.sess_req = 3'b111;
        end
        for (int g = 0; g < 4; g++) check("rr_order", 64'(order[g]), 64'(want[g]));
        bus.sess_req = '0;
        tick(); tick();

        // Allocation answered after 6 cycles
        do_reset();
        bus.sess_req = 3'b010;
        wait_gnt(cyc);
        check("alloc_owner", 64'(bus.sess_gnt), 64'(3'b010));
        set_alloc(1, 2, 3);
        tick();
        bus.own_alloc_req = '0;
        check("alloc_req_pulse", 64'(bus.alloc_req), 64'(1));
        check("alloc_m", 64'(bus.alloc_m), 64'(2));
        check("alloc_n", 64'(bus.alloc_n), 64'(3));
        tick();
        check("alloc_req_single", 64'(bus.alloc_req), 64'(0));
        repeat (4) tick();
        bus.alloc_valid = 1'b1; bus.alloc_id_in = 7'h12;
        tick();
        bus.alloc_valid = 1'b0;
        check("alloc_done", 64'(bus.own_alloc_done), 64'(3'b010));
        check("alloc_id_out", 64'(bus.alloc_id_out), 64'(7'h12));
        tick();
        check("alloc_done_single", 64'(bus.own_alloc_done), 64'(0));
        check("alloc_id_hold", 64'(bus.alloc_id_out), 64'(7'h12));

        // Allocator silent: timeout after ALLOC_TIMEOUT cycles, session kept
        set_alloc(1, 5, 6);
        tick();
        bus.own_alloc_req = '0;
        check("to_alloc_req", 64'(bus.alloc_req), 64'(1));
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.own_alloc_err != '0) begin
                k = c;
                break;
            end
        end
        check("to_err_delay", 64'(k), 64'(8));
        check("to_err_owner", 64'(bus.own_alloc_err), 64'(3'b010));
        tick();
        check("to_still_owned", 64'(bus.sess_gnt), 64'(3'b010));
        set_alloc(1, 1, 4);
        tick();
        bus.own_alloc_req = '0;
        check("to_back_in_own", 64'(bus.alloc_req), 64'(1));
        bus.alloc_valid = 1'b1; bus.alloc_id_in = 7'h21;
        tick();
        bus.alloc_valid = 1'b0;
        check("to_recover_done", 64'(bus.own_alloc_done), 64'(3'b010));
        bus.sess_req = '0;
        tick(); tick();

        // Non-owner strobes are discarded and flagged once
        do_reset();
        bus.sess_req = 3'b001;
        wait_gnt(cyc);
        set_wr(2, 9, 3, 3, 171);
        tick();
        bus.own_we = '0;
        check("viol_mem_we", 64'(bus.mem_we), 64'(0));
        check("viol_bus_err", 64'(bus.bus_err), 64'(1));
        tick();
        check("viol_err_single", 64'(bus.bus_err), 64'(0));
        set_wr(1, 4, 4, 4, 4);
        set_alloc(2, 3, 3);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.own_we = '0; bus.own_alloc_req = '0;
            if (c == 0) check("viol_no_alloc", 64'(bus.alloc_req), 64'(0));
            pulses += int'(bus.bus_err);
        end
        check("viol_merged_pulse", 64'(pulses), 64'(1));

        // Owner leaves during allocation wait; done still delivered
        set_alloc(0, 1, 1);
        tick();
        bus.own_alloc_req = '0;
        tick();
        bus.sess_req = '0;
        tick();
        bus.alloc_valid = 1'b1; bus.alloc_id_in = 7'h33;
        tick();
        bus.alloc_valid = 1'b0;
        check("leave_done", 64'(bus.own_alloc_done), 64'(3'b001));
        check("leave_gnt_clear", 64'(bus.sess_gnt), 64'(0));
        check("leave_id", 64'(bus.alloc_id_out), 64'(7'h33));
        tick();

        // Reset during allocation wait clears everything at once
        bus.sess_req = 3'b001;
        wait_gnt(cyc);
        set_alloc(0, 2, 2);
        tick();
        bus.own_alloc_req = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("arst_gnt", 64'(bus.sess_gnt), 64'(0));
        check("arst_alloc_id", 64'(bus.alloc_id_out), 64'(0));
        check("arst_alloc_m", 64'(bus.alloc_m), 64'(0));
        tick();
        clear_inputs();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            pulses += int'(|bus.own_alloc_done) + int'(|bus.own_alloc_err);
        end
        check("arst_no_pulse", 64'(pulses), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
